xor_r_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined XOR-reduction tree (`xor_r`) among `NUM_REQ` requesters. Each cycle it grants at most one valid request, drives that requester's word into the tree, and carries a tag alongside the tree pipeline. When the tag reaches the end of the pipeline, the parity bit is returned to the originating requester. It sits between the FEC/parity clients and the single shared reduction instance, and supports a halt input that stops new grants while the pipeline drains.

---
 rtl/xor_r_arb_pkg.sv | 48 ++++
 rtl/xor_r.sv | 42 ++++
 rtl/xor_r_arb_rr_arb.sv | 30 +++
 rtl/xor_r_arb.sv | 89 ++++++++
 tb/tb_xor_r_arb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/xor_r_arb_pkg.sv
// Shared helpers for the round-robin XOR-reduction sequencer: tree sizing rules
// and the tag record that travels alongside the reduction pipeline.
package xor_r_arb_pkg;

  localparam int MAX_REQ = 16;

  // Fan-in used by the next tree level, or 0 when the width cannot be split.
  function automatic int xor_r_next_k(input int width);
    if (width % 6 == 0) return 6;
    if (width % 5 == 0) return 5;
    if (width % 4 == 0) return 4;
    return 0;
  endfunction

  function automatic bit xor_r_width_ok(input int width);
    int w;
    int k;
    w = width;
    if (w < 1) return 1'b0;
    while (w > 6) begin
      k = xor_r_next_k(w);
      if (k == 0) return 1'b0;
      w = w / k;
    end
    return 1'b1;
  endfunction

  function automatic int xor_r_latency(input int width);
    int w;
    int k;
    int lat;
    w   = width;
    lat = 1;
    while (w > 6) begin
      k = xor_r_next_k(w);
      if (k == 0) return lat;
      w   = w / k;
      lat = lat + 1;
    end
    return lat;
  endfunction

  typedef struct packed {
    logic               vld;
    logic [MAX_REQ-1:0] id;
  } tag_t;

endpackage

// File: rtl/xor_r.sv
// Pipelined XOR-reduction tree: one register per level, fan-in 6/5/4 chosen
// from the width, final level reduces at most 6 bits. No reset on the datapath.
module xor_r
  import xor_r_arb_pkg::*;
#(
  parameter int WIDTH       = 30,
  parameter int TARGET_CHIP = 2
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  localparam int K = xor_r_next_k(WIDTH);

  if (TARGET_CHIP < 0) begin : g_bad_chip
    $error("xor_r: TARGET_CHIP must be non-negative");
  end

  if (WIDTH <= 6) begin : g_leaf
    logic dout_d, dout_q;
    always_comb dout_d = ^din;
    always_ff @(posedge clk) dout_q <= dout_d;
    assign dout = dout_q;
  end else if (K != 0) begin : g_node
    localparam int N = WIDTH / K;
    logic [N-1:0] part_d, part_q;
    always_comb begin
      part_d = '0;
      for (int j = 0; j < N; j++) part_d[j] = ^din[j*K +: K];
    end
    always_ff @(posedge clk) part_q <= part_d;
    xor_r #(.WIDTH(N), .TARGET_CHIP(TARGET_CHIP)) u_next (
      .clk  (clk),
      .din  (part_q),
      .dout (dout)
    );
  end else begin : g_bad_width
    $error("xor_r: unsupported WIDTH %0d", WIDTH);
  end

endmodule

// File: rtl/xor_r_arb_rr_arb.sv
// Combinational round-robin pick: first valid requester after 'last', wrapping.
module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      cand = (int'(last) + o) % NUM_REQ;
      if (!any && valid[cand[IW-1:0]]) begin
        any               = 1'b1;
        idx               = cand[IW-1:0];
        grant[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_r_arb.sv
// Shares one pipelined XOR-reduction tree among NUM_REQ requesters; a tag
// pipeline matching the tree latency routes each parity back to its owner.
module xor_r_arb
  import xor_r_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 30,
  parameter int TARGET_CHIP = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     halt,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     rsp_parity,
  output logic                     busy
);

  localparam int LAT = xor_r_latency(WIDTH);
  localparam int IW  = $clog2(NUM_REQ);

  if (!xor_r_width_ok(WIDTH)) begin : g_bad_width
    $error("xor_r_arb: WIDTH %0d not supported by xor_r", WIDTH);
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_req
    $error("xor_r_arb: NUM_REQ %0d out of range", NUM_REQ);
  end

  logic [IW-1:0]      last_d, last_q;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               xfer;
  logic [WIDTH-1:0]   tree_in;
  tag_t               tag_d [LAT];
  tag_t               tag_q [LAT];

  rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // arst gates the grant combinationally so nothing is offered mid-reset.
  assign xfer      = pick_any & ~halt & ~arst;
  assign req_ready = xfer ? pick : '0;

  always_comb begin
    tree_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) tree_in |= req_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    last_d                 = xfer ? pick_idx : last_q;
    tag_d[0].vld           = xfer;
    tag_d[0].id            = '0;
    tag_d[0].id[NUM_REQ-1:0] = pick;
    for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      last_q <= IW'(NUM_REQ - 1);
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      last_q <= last_d;
      tag_q  <= tag_d;
    end
  end

  xor_r #(.WIDTH(WIDTH), .TARGET_CHIP(TARGET_CHIP)) u_tree (
    .clk  (clk),
    .din  (tree_in),
    .dout (rsp_parity)
  );

  assign rsp_valid = tag_q[LAT-1].vld ? tag_q[LAT-1].id[NUM_REQ-1:0] : '0;

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) busy = busy | tag_q[s].vld;
  end

endmodule

// File: tb/tb_xor_r_arb.sv
// Bench for xor_r_arb: vector table plus randomized traffic against a queue
// model, and a WIDTH=32 instance for the three-stage tree.
module tb_xor_r_arb;

  localparam int N   = 4;
  localparam int W   = 30;
  localparam int LAT = 2;
  localparam int N2  = 2;
  localparam int W2  = 32;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic              halt;
  logic [N-1:0]      valid;
  logic [N*W-1:0]    data;
  logic [N-1:0]      ready, rspv;
  logic              par, busy;

  logic              halt_b;
  logic [N2-1:0]     valid_b;
  logic [N2*W2-1:0]  data_b;
  logic [N2-1:0]     ready_b, rspv_b;
  logic              par_b, busy_b;

  xor_r_arb #(.NUM_REQ(N), .WIDTH(W), .TARGET_CHIP(2)) dut (
    .clk(clk), .arst(arst), .halt(halt), .req_valid(valid), .req_data(data),
    .req_ready(ready), .rsp_valid(rspv), .rsp_parity(par), .busy(busy)
  );

  xor_r_arb #(.NUM_REQ(N2), .WIDTH(W2), .TARGET_CHIP(2)) dut_b (
    .clk(clk), .arst(arst), .halt(halt_b), .req_valid(valid_b), .req_data(data_b),
    .req_ready(ready_b), .rsp_valid(rspv_b), .rsp_parity(par_b), .busy(busy_b)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: outstanding items with the cycle their response is due.
  typedef struct { int due; int id; bit p; } item_t;
  item_t q[$];
  int    m_last;
  int    cyc = 0;

  function automatic int model_pick();
    if (halt) return -1;
    for (int o = 1; o <= N; o++)
      if (valid[(m_last + o) % N]) return (m_last + o) % N;
    return -1;
  endfunction

  // Entered just after a rising edge with inputs already applied.
  task automatic tick(input int tr, input int ts, output int g);
    int exp_rv;
    bit exp_p;
    logic [W-1:0] w;
    @(negedge clk);
    g      = model_pick();
    exp_rv = 0;
    exp_p  = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv = 1 << q[0].id;
      exp_p  = q[0].p;
    end
    chk("ready", ready, (g < 0) ? 0 : (1 << g));
    if (tr >= 0) chk("tbl_ready", ready, tr);
    if (ts >= 0) chk("tbl_rsp", rspv, ts);
    chk("rsp_valid", rspv, exp_rv);
    if (exp_rv != 0) chk("rsp_parity", par, exp_p);
    chk("busy", busy, q.size() > 0);
    @(posedge clk);
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (g >= 0) begin
      w = data[g*W +: W];
      q.push_back('{cyc + LAT, g, ($countones(w) % 2) == 1});
      m_last = g;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    halt = 1'b0; valid = '1; valid_b = '1;
    arst = 1'b1;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rsp_valid", rspv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_b", ready_b, 0);
    @(posedge clk); @(posedge clk);
    valid = '0; valid_b = '0;
    #3 arst = 1'b0;
    q.delete();
    m_last = N - 1;
    @(posedge clk); #1;
  endtask

  typedef struct { bit h; logic [N-1:0] v; int r; int s; } vec_t;
  vec_t tv[22];

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    logic [31:0] wv [3];
    bit          ep [3];

    halt = 1'b0; valid = '0; data = '0;
    halt_b = 1'b0; valid_b = '0; data_b = '0;
    arst = 1'b1;
    for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);

    // All valid from reset: grants 0..3 twice, responses LAT behind.
    for (int k = 0; k < 8; k++)
      tv[k] = '{1'b0, 4'b1111, 1 << (k % 4), (k < 2) ? 0 : (1 << ((k - 2) % 4))};
    tv[8]  = '{1'b0, 4'b0000, 0, 4};
    tv[9]  = '{1'b0, 4'b0000, 0, 8};
    // Single request from requester 2 (word 7 -> parity 1).
    tv[10] = '{1'b0, 4'b0000, 0, 0};
    tv[11] = '{1'b0, 4'b0100, 4, 0};
    tv[12] = '{1'b0, 4'b0000, 0, 0};
    tv[13] = '{1'b0, 4'b0000, 0, 4};
    // Halt with two in flight; resumes at last+1.
    tv[14] = '{1'b0, 4'b1111, 8, 0};
    tv[15] = '{1'b0, 4'b1111, 1, 0};
    tv[16] = '{1'b1, 4'b1111, 0, 8};
    tv[17] = '{1'b1, 4'b1111, 0, 1};
    tv[18] = '{1'b1, 4'b1111, 0, 0};
    tv[19] = '{1'b0, 4'b1111, 2, 0};
    tv[20] = '{1'b0, 4'b0000, 0, 0};
    tv[21] = '{1'b0, 4'b0000, 0, 2};

    do_reset();

    for (int k = 0; k < 22; k++) begin
      halt  = tv[k].h;
      valid = tv[k].v;
      if (tv[k].v == 4'b0100) data[2*W +: W] = 30'h7;
      tick(tv[k].r, tv[k].s, g);
      if (g >= 0) data[g*W +: W] = W'($urandom);
    end
    halt = 1'b0;

    // Async reset pulse between edges with two items in flight.
    valid = '1;
    tick(-1, -1, g); data[g*W +: W] = W'($urandom);
    tick(-1, -1, g); data[g*W +: W] = W'($urandom);
    #1 arst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rspv, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    #1 arst = 1'b0;
    q.delete();
    m_last = N - 1;
    tick(1, 0, g); data[g*W +: W] = W'($urandom);
    tick(2, 0, g); data[g*W +: W] = W'($urandom);
    valid = '0;
    for (int k = 0; k < 3; k++) tick(-1, -1, g);

    // Randomized traffic honouring hold-until-accepted.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!valid[i] && $urandom_range(0, 1) == 1) begin
          valid[i] = 1'b1;
          data[i*W +: W] = W'($urandom);
        end
      halt = ($urandom_range(0, 4) == 0);
      tick(-1, -1, g);
      if (g >= 0) valid[g] = 1'b0;
    end
    halt = 1'b0; valid = '0;
    for (int k = 0; k < 4; k++) tick(-1, -1, g);

    // WIDTH=32: three back-to-back words, parities three cycles later.
    wv[0] = 32'hFFFF_FFFF; wv[1] = 32'h8000_0000; wv[2] = 32'h0;
    ep[0] = 1'b0;          ep[1] = 1'b1;          ep[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_b = 2'b01;
      data_b[W2-1:0] = wv[k];
      @(negedge clk);
      chk("w32_ready", ready_b, 1);
      @(posedge clk); #1;
    end
    valid_b = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("w32_rsp_valid", rspv_b, 1);
      chk("w32_parity", par_b, ep[k]);
      chk("w32_busy", busy_b, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("w32_idle_rsp", rspv_b, 0);
    chk("w32_idle_busy", busy_b, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
